// File: rtl/ps2_scancode_rx_pkg.sv
// Shared constants and FSM encoding for the PS/2 keyboard receiver.
// The keyboard and mouse front ends both import this package.
package ps2_scancode_rx_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_scancode_rx_deglitch.sv
// Synchroniser and level filter for a PS/2 clock/data pin pair.
// Emits a one-cycle fall event together with the data level that matches that edge.
module ps2_deglitch #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clkps2,
    input  logic i_dataps2,
    output logic o_clk_filt,
    output logic o_fall,
    output logic o_data
);

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [FILTER_LEN-1:0] r_clk_hist;
    logic [FILTER_LEN-1:0] r_data_dly;
    logic                  r_filt;
    logic                  r_fall;
    logic                  r_data_smp;
    logic                  w_filt_next;

    always_comb begin
        w_filt_next = r_filt;
        if (r_clk_hist == '0)
            w_filt_next = 1'b0;
        else if (r_clk_hist == '1)
            w_filt_next = 1'b1;
    end

    // The data delay line runs in lockstep with the clock history, so its oldest
    // entry is the data level at the first low clock sample of the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_hist  <= '1;
            r_data_dly  <= '1;
            r_filt      <= 1'b1;
            r_fall      <= 1'b0;
            r_data_smp  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_clkps2};
            r_data_sync <= {r_data_sync[0], i_dataps2};
            r_clk_hist  <= {r_clk_hist[FILTER_LEN-2:0], r_clk_sync[1]};
            r_data_dly  <= {r_data_dly[FILTER_LEN-2:0], r_data_sync[1]};
            r_filt      <= w_filt_next;
            r_fall      <= r_filt & ~w_filt_next;
            if (r_filt && !w_filt_next)
                r_data_smp <= r_data_dly[FILTER_LEN-1];
        end
    end

    assign o_clk_filt = r_filt;
    assign o_fall     = r_fall;
    assign o_data     = r_data_smp;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, folds E0/F0 prefixes into flags
// and emits one key event per make/break code plus framing and timeout strobes.
module ps2_scancode_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 7000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clkps2,
    input  logic       dataps2,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       released,
    output logic       valid,
    output logic       frame_err,
    output logic       timeout_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t      r_state;
    ps2_state_t      w_next_state;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_par;
    logic            r_parity_ok;
    logic            r_ext;
    logic            r_rel;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_scancode;
    logic            r_extended;
    logic            r_released;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_timeout_err;
    logic            w_fall;
    logic            w_data;
    logic            w_accept;
    logic            w_frame_err;
    logic            w_timeout;

    ps2_deglitch #(.FILTER_LEN(FILTER_LEN)) u_deglitch (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clkps2   (clkps2),
        .i_dataps2  (dataps2),
        .o_clk_filt (),
        .o_fall     (w_fall),
        .o_data     (w_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // A fall event always beats the timeout when both land on the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_frame_err  = 1'b0;
        w_timeout    = 1'b0;
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_data)
                        w_frame_err = 1'b1;
                    else
                        w_next_state = ST_DATA;
                end
                ST_DATA: begin
                    if (r_bit_cnt == 3'd7)
                        w_next_state = ST_PARITY;
                end
                ST_PARITY: w_next_state = ST_STOP;
                ST_STOP: begin
                    w_next_state = ST_IDLE;
                    if (w_data && r_parity_ok)
                        w_accept = 1'b1;
                    else
                        w_frame_err = 1'b1;
                end
                default: w_next_state = ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE && r_to_cnt == TO_LAST) begin
            w_timeout    = 1'b1;
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (w_fall || r_state == ST_IDLE)
            r_to_cnt <= '0;
        else if (r_to_cnt != TO_MAX)
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Prefix flags persist across frames until a code byte or an error consumes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_par         <= 1'b0;
            r_parity_ok   <= 1'b0;
            r_ext         <= 1'b0;
            r_rel         <= 1'b0;
            r_scancode    <= '0;
            r_extended    <= 1'b0;
            r_released    <= 1'b0;
            r_valid       <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_valid       <= 1'b0;
            r_frame_err   <= w_frame_err;
            r_timeout_err <= w_timeout;
            if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        r_bit_cnt <= '0;
                        r_par     <= 1'b0;
                    end
                    ST_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_par     <= r_par ^ w_data;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    ST_PARITY: r_parity_ok <= r_par ^ w_data;
                    default: ;
                endcase
            end
            if (w_accept) begin
                if (r_shift == PS2_PREFIX_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == PS2_PREFIX_REL) begin
                    r_rel <= 1'b1;
                end else begin
                    r_scancode <= r_shift;
                    r_extended <= r_ext;
                    r_released <= r_rel;
                    r_valid    <= 1'b1;
                    r_ext      <= 1'b0;
                    r_rel      <= 1'b0;
                end
            end
            if (w_frame_err || w_timeout) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end
        end
    end

    assign scancode    = r_scancode;
    assign extended    = r_extended;
    assign released    = r_released;
    assign valid       = r_valid;
    assign frame_err   = r_frame_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames on the pins and checks
// delivered codes, prefix flags and error strobes against hand-computed values.
module tb_ps2_scancode_rx;
    import ps2_scancode_rx_pkg::*;

    localparam int FILT = 8;
    localparam int TOUT = 500;
    localparam int HALF = 40;

    logic       clk;
    logic       rst_n;
    logic       clkps2;
    logic       dataps2;
    logic [7:0] scancode;
    logic       extended;
    logic       released;
    logic       valid;
    logic       frame_err;
    logic       timeout_err;

    int checks = 0;
    int fails  = 0;
    int validCnt = 0;
    int ferrCnt  = 0;
    int toCnt    = 0;
    int overlapCnt = 0;
    int vBase, fBase, tBase;

    ps2_scancode_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clkps2      (clkps2),
        .dataps2     (dataps2),
        .scancode    (scancode),
        .extended    (extended),
        .released    (released),
        .valid       (valid),
        .frame_err   (frame_err),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) validCnt++;
        if (frame_err) ferrCnt++;
        if (timeout_err) toCnt++;
        if (int'(valid) + int'(frame_err) + int'(timeout_err) > 1) overlapCnt++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        vBase = validCnt;
        fBase = ferrCnt;
        tBase = toCnt;
    endtask

    // One PS/2 bit: data changes while the clock is high, the receiver samples on the fall.
    task automatic sendBit(input logic b, input bit glitch);
        dataps2 = b;
        if (glitch) begin
            waitCycles(HALF / 2);
            clkps2 = 1'b0;
            waitCycles(1);
            clkps2 = 1'b1;
            waitCycles(HALF / 2 - 1);
        end else begin
            waitCycles(HALF);
        end
        clkps2 = 1'b0;
        waitCycles(HALF);
        clkps2 = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit badParity, input bit glitch,
                                 input int resetAtBit);
        logic [10:0] frame;
        frame = {1'b1, (~^b) ^ badParity, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == resetAtBit) begin
                dataps2 = frame[i];
                waitCycles(HALF);
                clkps2 = 1'b0;
                waitCycles(HALF / 2);
                rst_n = 1'b0;
                #1;
                checkOutput("rst_async_code", scancode, 0);
                checkOutput("rst_async_flags", {extended, released, valid, frame_err, timeout_err}, 0);
                waitCycles(3);
                rst_n = 1'b1;
                waitCycles(HALF / 2 - 3);
                clkps2 = 1'b1;
            end else begin
                sendBit(frame[i], glitch);
            end
        end
        dataps2 = 1'b1;
        waitCycles(100);
    endtask

    initial begin
        logic found;
        logic seen;
        int cycles;
        rst_n   = 1'b0;
        clkps2  = 1'b1;
        dataps2 = 1'b1;
        waitCycles(3);
        checkOutput("reset_code", scancode, 0);
        checkOutput("reset_flags", {extended, released, valid, frame_err, timeout_err}, 0);
        checkOutput("reset_state", 32'(dut.r_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        waitCycles(20);

        snap();
        applyStimulus(8'h1C, 0, 0, -1);
        checkOutput("a_valid_cnt", validCnt - vBase, 1);
        checkOutput("a_code", scancode, 8'h1C);
        checkOutput("a_flags", {extended, released}, 0);
        checkOutput("a_errs", (ferrCnt - fBase) + (toCnt - tBase), 0);

        snap();
        applyStimulus(8'hE0, 0, 0, -1);
        applyStimulus(8'hF0, 0, 0, -1);
        applyStimulus(8'h75, 0, 0, -1);
        checkOutput("up_brk_valid_cnt", validCnt - vBase, 1);
        checkOutput("up_brk_code", scancode, 8'h75);
        checkOutput("up_brk_flags", {extended, released}, 2'b11);
        applyStimulus(8'h1C, 0, 0, -1);
        checkOutput("after_brk_flags", {extended, released}, 0);
        checkOutput("after_brk_code", scancode, 8'h1C);

        applyStimulus(8'h33, 0, 0, -1);
        snap();
        applyStimulus(8'hF0, 0, 0, -1);
        applyStimulus(8'h1C, 1, 0, -1);
        checkOutput("bad_par_ferr", ferrCnt - fBase, 1);
        checkOutput("bad_par_valid", validCnt - vBase, 0);
        checkOutput("bad_par_code_held", scancode, 8'h33);
        applyStimulus(8'h1C, 0, 0, -1);
        checkOutput("bad_par_next_code", scancode, 8'h1C);
        checkOutput("bad_par_next_rel", released, 0);

        snap();
        applyStimulus(8'hAA, 0, 0, -1);
        checkOutput("aa_valid_cnt", validCnt - vBase, 1);
        checkOutput("aa_code", scancode, 8'hAA);

        // Partial frame: start bit plus four data bits, then the clock goes quiet.
        snap();
        sendBit(1'b0, 0);
        sendBit(1'b1, 0);
        sendBit(1'b0, 0);
        sendBit(1'b1, 0);
        dataps2 = 1'b1;
        waitCycles(HALF);
        clkps2 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dut.u_deglitch.o_fall) found = 1'b1;
        end
        checkOutput("to_fall_seen", found, 1);
        clkps2 = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < TOUT + 50 && !seen; i++) begin
            @(negedge clk);
            if (timeout_err) seen = 1'b1;
            else begin
                @(posedge clk);
                cycles++;
            end
        end
        checkOutput("to_seen", seen, 1);
        checkOutput("to_latency", cycles, TOUT);
        waitCycles(2);
        checkOutput("to_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
        checkOutput("to_cnt", toCnt - tBase, 1);
        checkOutput("to_no_valid", (validCnt - vBase) + (ferrCnt - fBase), 0);
        snap();
        applyStimulus(8'h29, 0, 0, -1);
        checkOutput("to_next_valid", validCnt - vBase, 1);
        checkOutput("to_next_code", scancode, 8'h29);

        snap();
        applyStimulus(8'h5A, 0, 1, -1);
        checkOutput("glitch_valid_cnt", validCnt - vBase, 1);
        checkOutput("glitch_code", scancode, 8'h5A);
        checkOutput("glitch_errs", (ferrCnt - fBase) + (toCnt - tBase), 0);

        applyStimulus(8'h16, 0, 0, 5);
        waitCycles(TOUT + 200);
        snap();
        applyStimulus(8'h16, 0, 0, -1);
        checkOutput("post_rst_valid", validCnt - vBase, 1);
        checkOutput("post_rst_code", scancode, 8'h16);
        checkOutput("post_rst_flags", {extended, released}, 0);

        checkOutput("strobe_overlap", overlapCnt, 0);

        $display("test done: total=%0d bad=%0d", checks, fails);
        $finish;
    end

endmodule
